// File: rtl/multicycle_ctrl_if.sv
// Purpose : bundles the control/status signals between the multicycle CPU
//           control FSM (master) and its datapath (slave).
// Ports   : opcode/funct/zero/mem_ready flow datapath -> controller; every
//           enable, mux select, aluc, illegal_op and state flow controller -> datapath.
interface multicycle_ctrl_if;
  // datapath -> controller
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  // controller -> datapath
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_en;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] aluc;
  logic [1:0] pc_source;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           aluc, pc_source, illegal_op, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_en, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           aluc, pc_source, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose : control FSM of the multicycle CPU: FETCH/DECODE/EXECUTE/MEM/WB sequencing.
// Latency : 3-5 cycles per instruction (j/beq 3, R/addi/sw 4, lw 5) plus memory stalls.
// Backpr. : FETCH, MEM_RD and MEM_WR hold until mem_ready (unless USE_MEM_READY=0).
// Ports   : clk, rst_n (async active-low); bus = multicycle_ctrl_if.master carrying
//           opcode/funct/zero/mem_ready in and all datapath controls plus state out.
module multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_EXEC_I   = 4'd11,
    S_WB_I     = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] aluc;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl_q;
  logic   mem_rdy;
  logic   fetch_go;
  logic   pc_write_all;

  function automatic logic funct_ok(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_OR) || (f == FN_SLL);
  endfunction

  function automatic logic insn_legal(input logic [5:0] op, input logic [5:0] f);
    case (op)
      OP_RTYPE:                            insn_legal = funct_ok(f);
      OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: insn_legal = 1'b1;
      default:                             insn_legal = 1'b0;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] f, input logic rdy);
    state_t bad_dest;
    bad_dest = ILLEGAL_TRAP ? S_HALT : S_FETCH;
    case (s)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     next_state = funct_ok(f) ? S_EXEC_R : bad_dest;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_EXEC_I;
          default:      next_state = bad_dest;
        endcase
      end
      // opcode is looked at again so lw/sw share one address state
      S_MEM_ADDR: next_state = (op == OP_LW) ? S_MEM_RD :
                               (op == OP_SW) ? S_MEM_WR : S_FETCH;
      S_MEM_RD:   next_state = rdy ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   next_state = rdy ? S_FETCH  : S_MEM_WR;
      S_EXEC_R:   next_state = S_WB_R;
      S_EXEC_I:   next_state = S_WB_I;
      S_HALT:     next_state = S_HALT;
      default:    next_state = S_FETCH;   // WB_*, BRANCH, JUMP, unused codes
    endcase
  endfunction

  // Control word for the state being entered; registered so outputs are glitch-free.
  function automatic ctrl_t moore_outs(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'd1;
      end
      S_DECODE:   c.alu_src_b = 2'd3;     // precompute branch target into ALUOut
      S_MEM_ADDR: begin
        c.alu_src_a = 2'd1;
        c.alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        c.alu_src_a = 2'd1;
        case (f)
          FN_SUB:  c.aluc = 3'b001;
          FN_OR:   c.aluc = 3'b010;
          FN_SLL: begin
            c.aluc      = 3'b011;
            c.alu_src_a = 2'd2;            // shamt feeds the shift amount
          end
          default: c.aluc = 3'b000;
        endcase
      end
      S_WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 2'd1;
        c.aluc          = 3'b001;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'd1;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'd2;
      end
      S_EXEC_I: begin
        c.alu_src_a = 2'd1;
        c.alu_src_b = 2'd2;
      end
      S_WB_I:  c.reg_write = 1'b1;
      default: c = '0;                    // INIT, HALT
    endcase
    return c;
  endfunction

  assign mem_rdy   = USE_MEM_READY ? bus.mem_ready : 1'b1;
  assign state_nxt = next_state(state, bus.opcode, bus.funct, mem_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_INIT;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= moore_outs(state_nxt, bus.funct);
    end
  end

  // IR and PC+4 load complete in the same cycle the fetch read returns.
  assign fetch_go     = (state == S_FETCH) && mem_rdy;
  assign pc_write_all = ctrl_q.pc_write | fetch_go;

  assign bus.pc_write      = pc_write_all;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.pc_en         = pc_write_all | (ctrl_q.pc_write_cond & bus.zero);
  assign bus.i_or_d        = ctrl_q.i_or_d;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.ir_write      = fetch_go;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.aluc          = ctrl_q.aluc;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.illegal_op    = (state == S_DECODE) && !insn_legal(bus.opcode, bus.funct);
  assign bus.state         = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if bus_t ();

  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  multicycle_ctrl #(.USE_MEM_READY(1'b1), .ILLEGAL_TRAP(1'b1)) dut_t (.clk(clk), .rst_n(rst_n), .bus(bus_t));

  // {pc_write,pc_write_cond,pc_en,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,
  //  reg_dst,reg_write,alu_src_a,alu_src_b,aluc,pc_source,illegal_op}
  logic [19:0] obs, obs_t;
  assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_en, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.aluc, bus.pc_source, bus.illegal_op};
  assign obs_t = {bus_t.pc_write, bus_t.pc_write_cond, bus_t.pc_en, bus_t.i_or_d, bus_t.mem_read,
                  bus_t.mem_write, bus_t.ir_write, bus_t.mem_to_reg, bus_t.reg_dst, bus_t.reg_write,
                  bus_t.alu_src_a, bus_t.alu_src_b, bus_t.aluc, bus_t.pc_source, bus_t.illegal_op};

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic        mr;
    logic        z;
    logic [19:0] v;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [5:0] cur_op, cur_f;

  // Reference control word per state, straight from the state table.
  function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic [5:0] op,
                                          input logic [5:0] f, input logic mr, input logic z);
    logic pw, pwc, pe, iod, mrd, mwr, irw, m2r, rd, rw, ill;
    logic [1:0] sa, sbb, ps;
    logic [2:0] alu;
    logic legal;
    {pw, pwc, pe, iod, mrd, mwr, irw, m2r, rd, rw, ill} = '0;
    sa = 2'd0; sbb = 2'd0; ps = 2'd0; alu = 3'd0;
    legal = ((op == 6'b000000) && (f == 6'b100000 || f == 6'b100010 || f == 6'b100101 || f == 6'b000000))
            || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    case (st)
      4'd1:  begin mrd = 1; sbb = 2'd1; irw = mr; pw = mr; pe = mr; end
      4'd2:  begin sbb = 2'd3; ill = !legal; end
      4'd3:  begin sa = 2'd1; sbb = 2'd2; end
      4'd4:  begin mrd = 1; iod = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mwr = 1; iod = 1; end
      4'd7: begin
        if (f == 6'b000000) begin sa = 2'd2; alu = 3'b011; end
        else begin
          sa = 2'd1;
          alu = (f == 6'b100010) ? 3'b001 : (f == 6'b100101) ? 3'b010 : 3'b000;
        end
      end
      4'd8:  begin rw = 1; rd = 1; end
      4'd9:  begin sa = 2'd1; alu = 3'b001; pwc = 1; ps = 2'd1; pe = z; end
      4'd10: begin pw = 1; ps = 2'd2; pe = 1; end
      4'd11: begin sa = 2'd1; sbb = 2'd2; end
      4'd12: rw = 1;
      default: ;
    endcase
    return {pw, pwc, pe, iod, mrd, mwr, irw, m2r, rd, rw, sa, sbb, alu, ps, ill};
  endfunction

  task automatic set_insn(input logic [5:0] op, input logic [5:0] f);
    cur_op = op; cur_f = f;
    bus.opcode = op;  bus.funct = f;
    bus_t.opcode = op; bus_t.funct = f;
  endtask

  task automatic drive(input logic mr, input logic z);
    bus.mem_ready = mr;  bus.zero = z;
    bus_t.mem_ready = mr; bus_t.zero = z;
  endtask

  task automatic push(input string name, input logic [3:0] st, input logic mr, input logic z);
    exp_t e;
    e.name = name; e.st = st; e.mr = mr; e.z = z;
    e.v = exp_vec(st, cur_op, cur_f, mr, z);
    sb.push_back(e);
  endtask

  // One queued entry per cycle: drive its inputs, check at the falling edge.
  task automatic run_queue();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      drive(e.mr, e.z);
      @(negedge clk);
      total++;
      if (bus.state !== e.st) begin
        bad++;
        $display("FAIL %s state: got %0d want %0d", e.name, bus.state, e.st);
      end
      total++;
      if (obs !== e.v) begin
        bad++;
        $display("FAIL %s outputs (state %0d): got %05h want %05h", e.name, e.st, obs, e.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    set_insn(6'd0, 6'd0);
    drive(1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.state !== 4'd0 || obs !== 20'h0) begin
      bad++;
      $display("FAIL reset_hold: state %0d out %05h want 0/0", bus.state, obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.state !== 4'd0) begin
      bad++;
      $display("FAIL reset_init: state %0d want 0", bus.state);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype(input string name, input logic [5:0] f);
    set_insn(6'b000000, f);
    push({name, "_fetch"}, 4'd1, 1'b1, 1'b0);
    push({name, "_decode"}, 4'd2, 1'b1, 1'b0);
    push({name, "_exec"}, 4'd7, 1'b1, 1'b0);
    push({name, "_wb"}, 4'd8, 1'b1, 1'b0);
    run_queue();
  endtask

  task automatic test_lw_stall();
    set_insn(6'b100011, 6'd0);
    push("lw_fetch", 4'd1, 1'b1, 1'b0);
    push("lw_decode", 4'd2, 1'b1, 1'b0);
    push("lw_addr", 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push("lw_rd_wait", 4'd4, 1'b0, 1'b0);
    push("lw_rd_done", 4'd4, 1'b1, 1'b0);
    push("lw_wb", 4'd5, 1'b1, 1'b0);
    run_queue();
  endtask

  task automatic test_sw();
    set_insn(6'b101011, 6'd0);
    push("sw_fetch", 4'd1, 1'b1, 1'b0);
    push("sw_decode", 4'd2, 1'b1, 1'b0);
    push("sw_addr", 4'd3, 1'b1, 1'b0);
    push("sw_wr_wait", 4'd6, 1'b0, 1'b0);
    push("sw_wr_done", 4'd6, 1'b1, 1'b0);
    run_queue();
  endtask

  task automatic test_beq(input logic z);
    set_insn(6'b000100, 6'd0);
    push("beq_fetch", 4'd1, 1'b1, z);
    push("beq_decode", 4'd2, 1'b1, z);
    push(z ? "beq_taken" : "beq_not_taken", 4'd9, 1'b1, z);
    run_queue();
  endtask

  task automatic test_jump_addi();
    set_insn(6'b000010, 6'd0);
    push("j_fetch", 4'd1, 1'b1, 1'b0);
    push("j_decode", 4'd2, 1'b1, 1'b0);
    push("j_jump", 4'd10, 1'b1, 1'b0);
    run_queue();
    set_insn(6'b001000, 6'd5);
    push("addi_fetch_stall", 4'd1, 1'b0, 1'b0);
    push("addi_fetch", 4'd1, 1'b1, 1'b0);
    push("addi_decode", 4'd2, 1'b1, 1'b0);
    push("addi_exec", 4'd11, 1'b1, 1'b0);
    push("addi_wb", 4'd12, 1'b1, 1'b0);
    run_queue();
  endtask

  task automatic test_illegal();
    set_insn(6'b111111, 6'd0);
    push("ill_fetch", 4'd1, 1'b1, 1'b0);
    push("ill_decode", 4'd2, 1'b1, 1'b0);
    push("ill_back_to_fetch", 4'd1, 1'b0, 1'b0);   // mem_ready low parks main DUT in FETCH
    run_queue();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (bus_t.state !== 4'd13 || obs_t !== 20'h0) begin
        bad++;
        $display("FAIL trap_halt cycle %0d: state %0d out %05h want 13/0", i, bus_t.state, obs_t);
      end
      @(posedge clk); #1;
    end
    // an unsupported R-type funct is also illegal
    set_insn(6'b000000, 6'b101010);
    push("ill_funct_fetch", 4'd1, 1'b1, 1'b0);
    push("ill_funct_decode", 4'd2, 1'b1, 1'b0);
    run_queue();
  endtask

  task automatic test_async_reset();
    set_insn(6'b101011, 6'd0);
    push("rst_fetch", 4'd1, 1'b1, 1'b0);
    push("rst_decode", 4'd2, 1'b1, 1'b0);
    push("rst_addr", 4'd3, 1'b1, 1'b0);
    push("rst_wr", 4'd6, 1'b0, 1'b0);
    run_queue();
    total++;
    if (bus.state !== 4'd6 || bus.mem_write !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_memwr: state %0d mem_write %b want 6/1", bus.state, bus.mem_write);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.mem_write !== 1'b0 || obs !== 20'h0) begin
      bad++;
      $display("FAIL async_reset: state %0d mem_write %b out %05h want 0/0/0", bus.state, bus.mem_write, obs);
    end
    total++;
    if (bus_t.state !== 4'd0) begin
      bad++;
      $display("FAIL trap_reset: state %0d want 0", bus_t.state);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.state !== 4'd0) begin
      bad++;
      $display("FAIL post_reset_init: state %0d want 0", bus.state);
    end
    @(posedge clk); #1;
    set_insn(6'b000000, 6'b100000);
    push("post_reset_fetch", 4'd1, 1'b1, 1'b0);
    run_queue();
  endtask

  initial begin
    test_reset();
    test_rtype("add", 6'b100000);
    test_rtype("sub", 6'b100010);
    test_rtype("or", 6'b100101);
    test_rtype("sll", 6'b000000);
    test_lw_stall();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jump_addi();
    test_illegal();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
